// File: rtl/event_counter_bank.sv
// -----------------------------------------------------------------------------
// event_counter_bank
//
// Bank of CHANNELS independent event counters for the dtcTester debug path.
// Each channel counts single-cycle increment strobes. When a counter is at its
// maximum value, a further strobe either wraps it to zero or holds it at the
// maximum, depending on SATURATE. Either way the channel's sticky overflow flag
// is set. A snap copies every live counter and flag into shadow registers in
// the same cycle. The shadows are read back one channel per cycle through a
// registered read port.
//
// Parameters
//   CHANNELS  number of counters (>= 1)
//   WIDTH     counter width in bits (>= 2)
//   SATURATE  0: wrap to 0 on overflow, 1: hold at 2^WIDTH-1
//   SELW      read-select width, 2^SELW >= CHANNELS
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   incr       in   per-channel increment strobes
//   clear      in   synchronous clear of live counters and live flags
//   snap       in   capture live counters and flags into the shadows
//   rd_en      in   read request for one shadow channel
//   rd_sel     in   shadow channel to read; an index >= CHANNELS reads 0/0
//   count      out  live counters, channel i at [i*WIDTH +: WIDTH]
//   ovf        out  live sticky overflow flags
//   snap_done  out  one-cycle pulse after each snap
//   rd_valid   out  one-cycle pulse after each read request
//   rd_data    out  shadow count of the channel that was read
//   rd_ovf     out  shadow overflow flag of the channel that was read
// -----------------------------------------------------------------------------
module event_counter_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 5,
    parameter int SATURATE = 0,
    parameter int SELW     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       incr,
    input  logic                      clear,
    input  logic                      snap,
    input  logic                      rd_en,
    input  logic [SELW-1:0]           rd_sel,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       ovf,
    output logic                      snap_done,
    output logic                      rd_valid,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_ovf
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam int               NSEL    = 2 ** SELW;

    logic [CHANNELS-1:0][WIDTH-1:0] count_q, count_d;
    logic [CHANNELS-1:0]            ovf_q, ovf_d;
    logic [CHANNELS-1:0][WIDTH-1:0] shadow_cnt_q;
    logic [CHANNELS-1:0]            shadow_ovf_q;
    logic                           snap_done_q;
    logic                           rd_valid_q;
    logic [WIDTH-1:0]               rd_data_q, rd_data_d;
    logic                           rd_ovf_q, rd_ovf_d;

    // The shadows are zero-extended to the full rd_sel range. This makes an
    // out-of-range select read 0/0 without a separate range comparison.
    logic [NSEL-1:0][WIDTH-1:0]     shadow_cnt_ext;
    logic [NSEL-1:0]                shadow_ovf_ext;

    // Live counter next state. Priority is clear, then increment, then hold.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        count_d = count_q;
        ovf_d   = ovf_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (clear) begin
                count_d[i] = '0;
                ovf_d[i]   = 1'b0;
            end else if (incr[i]) begin
                if (count_q[i] == CNT_MAX) begin
                    count_d[i] = (SATURATE != 0) ? CNT_MAX : '0;
                    ovf_d[i]   = 1'b1;
                end else begin
                    count_d[i] = count_q[i] + WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        shadow_cnt_ext = '0;
        shadow_ovf_ext = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_cnt_ext[i] = shadow_cnt_q[i];
            shadow_ovf_ext[i] = shadow_ovf_q[i];
        end
    end

    // The read port holds its last value when no read is requested.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_ovf_d  = rd_ovf_q;
        if (rd_en) begin
            rd_data_d = shadow_cnt_ext[rd_sel];
            rd_ovf_d  = shadow_ovf_ext[rd_sel];
        end
    end

    // Snap and read both sample register values from before this edge. A snap
    // therefore excludes the increment or clear of the same edge. A read in
    // the same cycle as a snap returns the previous shadow contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the shadow registers are reset like any other state. A
            // read after reset must return a defined 0, not leftover contents.
            count_q      <= '0;
            ovf_q        <= '0;
            shadow_cnt_q <= '0;
            shadow_ovf_q <= '0;
            snap_done_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_ovf_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register here sample
            // the pre-edge value of the others, whatever the statement order.
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            snap_done_q <= snap;
            rd_valid_q  <= rd_en;
            rd_data_q   <= rd_data_d;
            rd_ovf_q    <= rd_ovf_d;
            if (snap) begin
                shadow_cnt_q <= count_q;
                shadow_ovf_q <= ovf_q;
            end
        end
    end

    assign count     = count_q;
    assign ovf       = ovf_q;
    assign snap_done = snap_done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_ovf    = rd_ovf_q;

endmodule
